ripple_count_ctrl: RTL and testbench
====================================

Name: ripple_count_ctrl

Overview:
- Sequences an external ripple-carry event counter, used to measure latency in cycles of online arithmetic operators.
- Clears the counter, then gates its enable for one measurement window delimited by start/stop.
- Waits for the asynchronous ripple to settle before capturing the count.
- Cross-checks the captured count against a synchronous shadow count, then presents the result on a valid/ready handshake.

Parameters:
- LENGTH, 14, width of the external counter, the shadow count and the result.
- CLR_CYCLES, 2, number of cycles cnt_clear is held high before a window opens (≥1).
- SETTLE_CYCLES, 16, number of cycles waited after the window closes before capture (≥1; ≥ LENGTH+2 for full ripple).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a measurement; sampled only in IDLE.
- stop  in  1  close the window; sampled only in RUN.
- cnt_value  in  LENGTH  external counter output.
- cnt_enable  out  1  external counter enable.
- cnt_clear  out  1  external counter clear.
- busy  out  1  high in any state other than IDLE.
- result  out  LENGTH  captured count.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- overflow  out  1  window force-closed at maximum count; qualified by result_valid.
- mismatch  out  1  captured count differs from shadow count; qualified by result_valid.

Behaviour:
- Reset:
  - Clock and reset: reset is synchronous, active-high; clock is clk.
  - Reset forces state IDLE.
  - All outputs 0: cnt_enable, cnt_clear, busy, result, result_valid, overflow, mismatch.
  - Shadow count and timer are set to 0.
  - Reset mid-operation aborts at the next edge. The external counter is not cleared by reset; the next start clears it.
- Output timing: all outputs are registered. Each output reflects the state held during that cycle.
- States and transitions:
  - IDLE: start=1 → CLEAR; load timer with CLR_CYCLES-1; zero the shadow count. stop is ignored.
  - CLEAR: cnt_clear=1, cnt_enable=0. When timer=0 → RUN; otherwise decrement timer.
  - RUN: cnt_enable=1, cnt_clear=0. The shadow count increments every RUN cycle.
    - Exit → SETTLE if stop=1, or if shadow count = 2^LENGTH-2 in that cycle (overflow condition). The exit cycle itself is counted.
    - On exit, load timer with SETTLE_CYCLES-1.
    - Overflow exit sets the overflow flag. The count never wraps; maximum result = 2^LENGTH-1.
    - stop and overflow in the same cycle: overflow=1.
  - SETTLE: cnt_enable=0, cnt_clear=0. When timer=0 → CAPTURE; otherwise decrement timer.
  - CAPTURE: one cycle.
    - result ← cnt_value.
    - mismatch ← (cnt_value ≠ shadow count).
    - → DONE.
  - DONE: result_valid=1; result, overflow and mismatch held stable.
    - result_ready=1 → IDLE; result_valid drops next cycle.
    - result_ready may be high on the first DONE cycle (single-cycle handshake).
- Measurement arithmetic:
  - Count = number of RUN cycles.
  - If stop is high on the first RUN cycle, count = 1.
  - stop asserted continuously from the start cycle also yields count = 1.
- Window timing: the window opens CLR_CYCLES+1 cycles after start is sampled.
- Ignored inputs:
  - start while busy: ignored, not queued.
  - stop outside RUN: ignored.
  - result_ready outside DONE: ignored.
- Retention: result, overflow and mismatch keep their values after DONE until the next CAPTURE or reset.
- Timer width: clog2(max(CLR_CYCLES, SETTLE_CYCLES)) + 1.

Test Plan:
- Basic: start pulse at cycle 0, stop at 7th RUN cycle, result_ready=1 → cnt_clear high 2 cycles, cnt_enable high exactly 7 cycles, 16 settle cycles, result=7, mismatch=0, overflow=0, result_valid for 1 cycle.
- Minimum window: start and stop held high together → cnt_enable high 1 cycle, result=1.
- Overflow: LENGTH=4, stop never asserted → cnt_enable high 15 cycles, result=15, overflow=1.
- Backpressure, ignored start, retention:
  - Hold result_ready=0 for 20 cycles in DONE; pulse start during DONE.
  - Required: result_valid stays high, result stable, no new measurement.
  - Raise result_ready → IDLE next cycle; result still readable after result_valid drops.
- Mismatch: counter model drops one increment in a 10-cycle window → result=9, mismatch=1.
- Reset mid-RUN: assert reset in the 3rd RUN cycle → next cycle: IDLE, all outputs 0, busy=0. A following start gives a correct count after the clear.

Source files
------------

// File: rtl/ripple_count_ctrl_if.sv
// Handshake and counter-side signals of ripple_count_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface ripple_count_ctrl_if #(
  parameter int LENGTH = 14
) ();
  logic              start;
  logic              stop;
  logic [LENGTH-1:0] cnt_value;
  logic              cnt_enable;
  logic              cnt_clear;
  logic              busy;
  logic [LENGTH-1:0] result;
  logic              result_valid;
  logic              result_ready;
  logic              overflow;
  logic              mismatch;

  modport master (
    output start, stop, cnt_value, result_ready,
    input  cnt_enable, cnt_clear, busy, result, result_valid, overflow, mismatch
  );

  modport slave (
    input  start, stop, cnt_value, result_ready,
    output cnt_enable, cnt_clear, busy, result, result_valid, overflow, mismatch
  );
endinterface

// File: rtl/ripple_count_ctrl.sv
// Sequences an external ripple counter: clear, gated window, settle, capture,
// then cross-checks the captured count against a synchronous shadow count.
module ripple_count_ctrl #(
  parameter int LENGTH        = 14,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  ripple_count_ctrl_if.slave bus
);

  localparam int MAX_TIMER = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W   = $clog2(MAX_TIMER) + 1;
  localparam logic [LENGTH-1:0] OVF_AT = {{(LENGTH-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [LENGTH-1:0]   shadow_q, shadow_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic                cnt_enable_q, cnt_enable_d;
  logic                cnt_clear_q, cnt_clear_d;
  logic                busy_q, busy_d;
  logic [LENGTH-1:0]   result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                overflow_q, overflow_d;
  logic                mismatch_q, mismatch_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    shadow_d     = shadow_q;
    ovf_flag_d   = ovf_flag_q;
    result_d     = result_q;
    overflow_d   = overflow_q;
    mismatch_d   = mismatch_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = CLEAR;
          timer_d    = TIMER_W'(CLR_CYCLES - 1);
          shadow_d   = '0;
          ovf_flag_d = 1'b0;
        end
      end
      CLEAR: begin
        if (timer_q == '0) state_d = RUN;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      RUN: begin
        // The exit cycle is itself counted; stopping one short of all-ones keeps the count from wrapping.
        shadow_d = shadow_q + LENGTH'(1);
        if (bus.stop || (shadow_q == OVF_AT)) begin
          state_d    = SETTLE;
          timer_d    = TIMER_W'(SETTLE_CYCLES - 1);
          ovf_flag_d = (shadow_q == OVF_AT);
        end
      end
      SETTLE: begin
        if (timer_q == '0) state_d = CAPTURE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      CAPTURE: begin
        result_d   = bus.cnt_value;
        mismatch_d = (bus.cnt_value != shadow_q);
        overflow_d = ovf_flag_q;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copy matches the state it accompanies.
    cnt_enable_d   = (state_d == RUN);
    cnt_clear_d    = (state_d == CLEAR);
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      shadow_q       <= '0;
      ovf_flag_q     <= 1'b0;
      cnt_enable_q   <= 1'b0;
      cnt_clear_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      mismatch_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      shadow_q       <= shadow_d;
      ovf_flag_q     <= ovf_flag_d;
      cnt_enable_q   <= cnt_enable_d;
      cnt_clear_q    <= cnt_clear_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      mismatch_q     <= mismatch_d;
    end
  end

  assign bus.cnt_enable   = cnt_enable_q;
  assign bus.cnt_clear    = cnt_clear_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.mismatch     = mismatch_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Bench for ripple_count_ctrl with a small LENGTH so the overflow path is reachable;
// an external counter model can be told to drop one increment.
module tb_ripple_count_ctrl;
  localparam int LENGTH        = 4;
  localparam int CLR_CYCLES    = 2;
  localparam int SETTLE_CYCLES = 16;
  localparam int MAXC          = (1 << LENGTH) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ripple_count_ctrl_if #(.LENGTH(LENGTH)) u_if ();

  ripple_count_ctrl #(
    .LENGTH(LENGTH),
    .CLR_CYCLES(CLR_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter: not touched by reset, optionally loses its Nth increment.
  logic [LENGTH-1:0] ext_cnt;
  int                en_seen;
  int                drop_at_run;
  initial begin
    ext_cnt     = 4'hA;
    en_seen     = 0;
    drop_at_run = 0;
  end
  always @(posedge clk) begin
    if (u_if.cnt_clear) begin
      ext_cnt <= '0;
      en_seen <= 0;
    end else if (u_if.cnt_enable) begin
      en_seen <= en_seen + 1;
      if (en_seen + 1 != drop_at_run) ext_cnt <= ext_cnt + 1'b1;
    end
  end
  assign u_if.cnt_value = ext_cnt;

  int en_cycles;
  int clr_cycles;
  always @(negedge clk) begin
    if (u_if.cnt_enable) en_cycles++;
    if (u_if.cnt_clear)  clr_cycles++;
  end

  // One measurement: n_stop = RUN cycle on which stop is sampled (0 = never), hold_stop keeps stop high throughout.
  task automatic run_measure(input string name, input int n_stop, input bit hold_stop,
                             input int drop_at, input int ready_wait, input bit poke_start);
    int exp_cnt;
    int exp_ext;
    bit exp_ovf;
    bit exp_mis;
    int exp_lat;
    int k;
    bit got;
    logic [LENGTH-1:0] held;

    if (hold_stop)                         exp_cnt = 1;
    else if (n_stop == 0 || n_stop >= MAXC) exp_cnt = MAXC;
    else                                   exp_cnt = n_stop;
    exp_ovf = !hold_stop && (n_stop == 0 || n_stop >= MAXC);
    exp_ext = exp_cnt - ((drop_at > 0 && drop_at <= exp_cnt) ? 1 : 0);
    exp_mis = (exp_ext != exp_cnt);
    exp_lat = CLR_CYCLES + exp_cnt + SETTLE_CYCLES + 1;

    @(negedge clk);
    drop_at_run = drop_at;
    en_cycles   = 0;
    clr_cycles  = 0;
    u_if.start  = 1'b1;
    u_if.stop   = hold_stop;
    @(negedge clk);
    u_if.start  = 1'b0;
    got = 1'b0;
    k   = 0;
    while (!got && k < 400) begin
      k++;
      if (!hold_stop) u_if.stop = (n_stop > 0) && (k == CLR_CYCLES + n_stop);
      @(negedge clk);
      if (u_if.result_valid === 1'b1) got = 1'b1;
    end
    u_if.stop = 1'b0;

    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s timeout: result_valid not seen within %0d cycles, required after %0d", name, k, exp_lat);
      return;
    end
    checks++;
    if (k !== exp_lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, k, exp_lat);
    end
    checks++;
    if (u_if.result !== LENGTH'(exp_ext)) begin
      errors++;
      $display("[TB] FAIL %s result: got %0d, expected %0d", name, u_if.result, exp_ext);
    end
    checks++;
    if (u_if.overflow !== exp_ovf) begin
      errors++;
      $display("[TB] FAIL %s overflow: got %b, expected %b", name, u_if.overflow, exp_ovf);
    end
    checks++;
    if (u_if.mismatch !== exp_mis) begin
      errors++;
      $display("[TB] FAIL %s mismatch: got %b, expected %b", name, u_if.mismatch, exp_mis);
    end
    checks++;
    if (en_cycles !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL %s enable_cycles: got %0d, expected %0d", name, en_cycles, exp_cnt);
    end
    checks++;
    if (clr_cycles !== CLR_CYCLES) begin
      errors++;
      $display("[TB] FAIL %s clear_cycles: got %0d, expected %0d", name, clr_cycles, CLR_CYCLES);
    end

    held = u_if.result;
    for (int i = 0; i < ready_wait; i++) begin
      u_if.start = poke_start && (i == 2);
      @(negedge clk);
      checks++;
      if (u_if.result_valid !== 1'b1 || u_if.result !== LENGTH'(exp_ext) || u_if.cnt_clear !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s hold: valid=%b result=%0d clear=%b, expected valid=1 result=%0d clear=0",
                 name, u_if.result_valid, u_if.result, u_if.cnt_clear, exp_ext);
      end
    end
    u_if.start        = 1'b0;
    u_if.result_ready = 1'b1;
    @(negedge clk);
    u_if.result_ready = 1'b0;
    checks++;
    if (u_if.result_valid !== 1'b0 || u_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s release: valid=%b busy=%b, expected 0 0", name, u_if.result_valid, u_if.busy);
    end
    checks++;
    if (u_if.result !== held || u_if.overflow !== exp_ovf || u_if.mismatch !== exp_mis) begin
      errors++;
      $display("[TB] FAIL %s retention: result=%0d ovf=%b mis=%b, expected %0d %b %b",
               name, u_if.result, u_if.overflow, u_if.mismatch, held, exp_ovf, exp_mis);
    end
    if (poke_start) begin
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.busy !== 1'b0 || u_if.cnt_clear !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s start_ignored: busy=%b clear=%b, expected 0 0", name, u_if.busy, u_if.cnt_clear);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({u_if.cnt_enable, u_if.cnt_clear, u_if.busy, u_if.result_valid, u_if.overflow, u_if.mismatch} !== 6'b0
        || u_if.result !== '0) begin
      errors++;
      $display("[TB] FAIL %s outputs: en=%b clr=%b busy=%b valid=%b ovf=%b mis=%b result=%0d, expected all 0",
               name, u_if.cnt_enable, u_if.cnt_clear, u_if.busy, u_if.result_valid,
               u_if.overflow, u_if.mismatch, u_if.result);
    end
  endtask

  task automatic test_reset();
    reset             = 1'b1;
    u_if.start        = 1'b0;
    u_if.stop         = 1'b0;
    u_if.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    run_measure("basic", 7, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_min_window();
    run_measure("min_window", 0, 1'b1, 0, 0, 1'b0);
    run_measure("stop_first_run", 1, 1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_overflow();
    run_measure("overflow", 0, 1'b0, 0, 0, 1'b0);
    run_measure("stop_at_overflow", MAXC, 1'b0, 0, 0, 1'b0);
    run_measure("stop_before_overflow", MAXC - 1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_measure("backpressure", 4, 1'b0, 0, 20, 1'b1);
  endtask

  task automatic test_mismatch();
    run_measure("mismatch", 10, 1'b0, 4, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    drop_at_run = 0;
    u_if.start  = 1'b1;
    @(negedge clk);
    u_if.start  = 1'b0;
    repeat (CLR_CYCLES + 2) @(negedge clk);
    checks++;
    if (u_if.cnt_enable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_run_setup: cnt_enable=%b, expected 1", u_if.cnt_enable);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset_mid_run");
    run_measure("after_reset", 5, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    int drop;
    for (int it = 0; it < 10; it++) begin
      n    = $urandom_range(1, MAXC + 2);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      run_measure("random", n, 1'b0, drop, $urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_min_window();
    test_overflow();
    test_backpressure();
    test_mismatch();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
